// File: rtl/init_seq_pkg.sv
// Shared types and helpers for the multi-channel power-on init sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t       sequencer state encoding
//   SIM_TIME_EXP  timer exponent used in simulation mode (16-cycle waits)
//   err_flag_pos  bit position of the error flag inside the error info bus
//   eff_exp       selects the effective timer exponent for a configured wait
package init_seq_pkg;

    typedef enum logic [2:0] {
        ST_PWR      = 3'd0,
        ST_ASSERT   = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    localparam logic [4:0] SIM_TIME_EXP = 5'd4;

    // The error flag occupies the MSB of the error info bus; the channel
    // index is packed below it.
    function automatic int unsigned err_flag_pos(input int unsigned wd_err_info);
        return wd_err_info - 1;
    endfunction

    // Simulation mode collapses every wait to 2^SIM_TIME_EXP cycles so that
    // a full sequence can be observed in a few hundred cycles.
    function automatic logic [4:0] eff_exp(input int unsigned sim_able,
                                           input int unsigned nb_time);
        return (sim_able != 0) ? SIM_TIME_EXP : 5'(nb_time);
    endfunction

endpackage

// File: rtl/init_seq_timer.sv
// Shared dwell timer: 32-bit up-counter with synchronous clear and a terminal flag at 2^exp-1.
// Latency: tc is combinational from the counter register; clear takes effect on the next edge.
// Backpressure: none; run=0 freezes the count, clr has priority over run.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         clear the count to 0 on the next edge
//   run         advance the count by one on the next edge
//   exp         runtime-selected exponent (0..31) of the current dwell
//   tc          high while the count equals 2^exp-1
module init_seq_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       run,
    input  logic [4:0] exp,
    output logic       tc
);

    logic [31:0] cnt;
    logic [31:0] limit;

    // exp=31 gives 2^31-1, which still fits the 32-bit counter.
    assign limit = (32'd1 << exp) - 32'd1;
    assign tc    = (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/init_seq_multi.sv
// Power-on init sequencer: settle wait, then releases NB_CHN channels one at a time with optional ack/timeout and gaps.
// Latency: all outputs registered; an output change appears one edge after the condition that causes it.
// Backpressure: none; i_init_done is the only handshake, bounded by the ack timeout.
//
// Ports:
//   i_sys_clk, i_sys_resetn  clock and asynchronous active-low reset
//   i_init_restart           synchronous restart, highest priority, level-sampled
//   i_init_done[NB_CHN]      per-channel ack; only the bit of the current channel is looked at
//   o_init_en[NB_CHN]        cumulative per-channel enable
//   o_init_update[NB_CHN]    one-cycle release pulse for the channel being enabled
//   o_init_busy              sequence in progress (PWR/ASSERT/WAIT_ACK/GAP)
//   o_init_all_done          every channel released and acknowledged
//   m_err_init_info1         {timeout flag, failing channel index}
module init_seq_multi
    import init_seq_pkg::*;
#(
    parameter int unsigned MD_SIM_ABLE  = 0,
    parameter int unsigned MD_ACK_ABLE  = 1,
    parameter int unsigned NB_CHN       = 4,
    parameter int unsigned NB_INIT_TIME = 28,
    parameter int unsigned NB_STEP_TIME = 20,
    parameter int unsigned NB_TOUT_TIME = 24,
    parameter int unsigned WD_ERR_INFO  = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    input  logic                   i_init_restart,
    input  logic [NB_CHN-1:0]      i_init_done,
    output logic [NB_CHN-1:0]      o_init_en,
    output logic [NB_CHN-1:0]      o_init_update,
    output logic                   o_init_busy,
    output logic                   o_init_all_done,
    output logic [WD_ERR_INFO-1:0] m_err_init_info1
);

    localparam int unsigned WD_K      = (NB_CHN > 1) ? $clog2(NB_CHN) : 1;
    localparam int unsigned ERR_POS   = err_flag_pos(WD_ERR_INFO);
    localparam logic [4:0]  EXP_INIT  = eff_exp(MD_SIM_ABLE, NB_INIT_TIME);
    localparam logic [4:0]  EXP_STEP  = eff_exp(MD_SIM_ABLE, NB_STEP_TIME);
    localparam logic [4:0]  EXP_TOUT  = eff_exp(MD_SIM_ABLE, NB_TOUT_TIME);
    localparam logic [WD_K-1:0] K_LAST = WD_K'(NB_CHN - 1);
    localparam bit          ACK_EN    = (MD_ACK_ABLE != 0);

    state_t                 state;
    state_t                 state_nxt;
    logic [WD_K-1:0]        k;
    logic [WD_K-1:0]        k_nxt;

    logic                   tmr_clr;
    logic                   tmr_run;
    logic [4:0]             tmr_exp;
    logic                   tmr_tc;

    logic [NB_CHN-1:0]      onehot_k;
    logic [NB_CHN-1:0]      en_nxt;
    logic [NB_CHN-1:0]      upd_nxt;
    logic                   busy_nxt;
    logic                   all_done_nxt;
    logic [WD_ERR_INFO-1:0] err_nxt;

    // ------------------------------------------------------------------
    // Shared dwell timer. Every state change (and every restart, even one
    // that re-enters PWR from PWR) restarts the count from zero, so each
    // state's dwell is measured from its own entry.
    // ------------------------------------------------------------------
    always_comb begin
        tmr_exp = EXP_STEP;
        case (state)
            ST_PWR:      tmr_exp = EXP_INIT;
            ST_WAIT_ACK: tmr_exp = EXP_TOUT;
            ST_GAP:      tmr_exp = EXP_STEP;
            default:     tmr_exp = EXP_STEP;
        endcase
    end

    assign tmr_clr = i_init_restart || (state_nxt != state);
    // Terminal states hold the count still; nothing there depends on it.
    assign tmr_run = (state != ST_DONE) && (state != ST_ERR);

    init_seq_timer u_timer (
        .clk   (i_sys_clk),
        .rst_n (i_sys_resetn),
        .clr   (tmr_clr),
        .run   (tmr_run),
        .exp   (tmr_exp),
        .tc    (tmr_tc)
    );

    // ------------------------------------------------------------------
    // State and channel-index register
    // ------------------------------------------------------------------
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state <= ST_PWR;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        if (i_init_restart) begin
            state_nxt = ST_PWR;
            k_nxt     = '0;
        end else begin
            case (state)
                ST_PWR: begin
                    if (tmr_tc) begin
                        state_nxt = ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    state_nxt = ACK_EN ? ST_WAIT_ACK : ST_GAP;
                end
                ST_WAIT_ACK: begin
                    // Ack is tested first so that an ack landing on the
                    // timeout edge still counts as success.
                    if (i_init_done[k]) begin
                        state_nxt = ST_GAP;
                    end else if (tmr_tc) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_GAP: begin
                    if (tmr_tc) begin
                        if (k == K_LAST) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_ASSERT;
                            k_nxt     = k + WD_K'(1);
                        end
                    end
                end
                ST_DONE: state_nxt = ST_DONE;
                ST_ERR:  state_nxt = ST_ERR;
                default: begin
                    state_nxt = ST_PWR;
                    k_nxt     = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output values for the next cycle, derived from the next state so the
    // registered outputs line up with the state register (Moore timing
    // without an extra cycle of lag).
    // ------------------------------------------------------------------
    always_comb begin
        onehot_k           = '0;
        onehot_k[k_nxt]    = 1'b1;
        en_nxt             = o_init_en;
        upd_nxt            = '0;
        err_nxt            = '0;
        busy_nxt           = (state_nxt == ST_PWR)      || (state_nxt == ST_ASSERT) ||
                             (state_nxt == ST_WAIT_ACK) || (state_nxt == ST_GAP);
        all_done_nxt       = (state_nxt == ST_DONE);
        if (i_init_restart) begin
            en_nxt = '0;
        end else if (state_nxt == ST_ASSERT) begin
            en_nxt  = o_init_en | onehot_k;
            upd_nxt = onehot_k;
        end else if (state_nxt == ST_ERR) begin
            // Withdraw only the channel that failed to ack; earlier
            // channels completed and stay enabled.
            en_nxt  = o_init_en & ~onehot_k;
            err_nxt = {1'b1, ERR_POS'(k_nxt)};
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            o_init_en        <= '0;
            o_init_update    <= '0;
            o_init_busy      <= 1'b0;
            o_init_all_done  <= 1'b0;
            m_err_init_info1 <= '0;
        end else begin
            o_init_en        <= en_nxt;
            o_init_update    <= upd_nxt;
            o_init_busy      <= busy_nxt;
            o_init_all_done  <= all_done_nxt;
            m_err_init_info1 <= err_nxt;
        end
    end

endmodule

// File: tb/tb_init_seq_multi.sv
// Testbench for init_seq_multi: two instances (ack enabled / ack disabled) in simulation mode.
// Expected output vectors come from closed-form cycle formulas and are queued per cycle.
// A negedge monitor pops and compares every queued vector for the current cycle.
module tb_init_seq_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic [3:0] done;
    logic       restart_na;
    logic [3:0] done_na;

    logic [3:0] en, upd, err;
    logic       busy, adone;
    logic [3:0] en_na, upd_na, err_na;
    logic       busy_na, adone_na;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;
    int cyc        = 0;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [13:0] vec;
        string       tag;
    } sb_t;

    sb_t sb[$];
    sb_t ent;

    init_seq_multi #(
        .MD_SIM_ABLE(1), .MD_ACK_ABLE(1), .NB_CHN(4),
        .NB_INIT_TIME(28), .NB_STEP_TIME(20), .NB_TOUT_TIME(24), .WD_ERR_INFO(4)
    ) dut (
        .i_sys_clk        (clk),
        .i_sys_resetn     (rst_n),
        .i_init_restart   (restart),
        .i_init_done      (done),
        .o_init_en        (en),
        .o_init_update    (upd),
        .o_init_busy      (busy),
        .o_init_all_done  (adone),
        .m_err_init_info1 (err)
    );

    init_seq_multi #(
        .MD_SIM_ABLE(1), .MD_ACK_ABLE(0), .NB_CHN(4),
        .NB_INIT_TIME(28), .NB_STEP_TIME(20), .NB_TOUT_TIME(24), .WD_ERR_INFO(4)
    ) dut_na (
        .i_sys_clk        (clk),
        .i_sys_resetn     (rst_n),
        .i_init_restart   (restart_na),
        .i_init_done      (done_na),
        .o_init_en        (en_na),
        .o_init_update    (upd_na),
        .o_init_busy      (busy_na),
        .o_init_all_done  (adone_na),
        .m_err_init_info1 (err_na)
    );

    always #5 clk = ~clk;

    wire [13:0] obs    = {en, upd, busy, adone, err};
    wire [13:0] obs_na = {en_na, upd_na, busy_na, adone_na, err_na};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Ack-enabled sequence. c is cycles since reset release (or since the
    // last restart edge when rs=1, where busy is already high at c<=0).
    function automatic logic [13:0] exp_ack(input int c, input bit rs);
        logic [3:0] e, u;
        logic       b, d;
        e = 4'b0;
        u = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (c == 16 + 18 * i) u[i] = 1'b1;
            if (c >= 16 + 18 * i) e[i] = 1'b1;
        end
        b = (c >= 1 || rs) && (c < 88);
        d = (c >= 88);
        return {e, u, b, d, 4'b0000};
    endfunction

    // Ack-disabled sequence: ASSERT goes straight to GAP, 17-cycle pitch.
    function automatic logic [13:0] exp_nack(input int c);
        logic [3:0] e, u;
        logic       b, d;
        e = 4'b0;
        u = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (c == 16 + 17 * i) u[i] = 1'b1;
            if (c >= 16 + 17 * i) e[i] = 1'b1;
        end
        b = (c >= 1) && (c < 84);
        d = (c >= 84);
        return {e, u, b, d, 4'b0000};
    endfunction

    // Channel 2 never acks: WAIT_ACK 53..68, ERR from 69.
    function automatic logic [13:0] exp_tout(input int c);
        if (c < 69) return exp_ack(c, 1'b0);
        return {4'b0011, 4'b0000, 1'b0, 1'b0, 4'b1010};
    endfunction

    // Channel 2 acks only on the timeout edge (68): GAP 69..84, ch3 ASSERT 85,
    // WAIT_ACK 86, GAP 87..102, DONE from 103.
    function automatic logic [13:0] exp_coll(input int c);
        if (c < 70)  return exp_ack(c, 1'b0);
        if (c < 85)  return {4'b0111, 4'b0000, 1'b1, 1'b0, 4'b0000};
        if (c == 85) return {4'b1111, 4'b1000, 1'b1, 1'b0, 4'b0000};
        if (c < 103) return {4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000};
        return {4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000};
    endfunction

    task automatic push(input bit sel, input logic [13:0] v, input string tag);
        sb_t s;
        s.cyc = cyc;
        s.sel = sel;
        s.vec = v;
        s.tag = tag;
        sb.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        restart    = 1'b0;
        restart_na = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ent = sb.pop_front();
            check_vec($sformatf("%s c%0d", ent.tag, ent.cyc),
                      32'(ent.sel ? obs_na : obs), 32'(ent.vec));
        end
    end

    initial begin
        rst_n      = 1'b0;
        restart    = 1'b0;
        restart_na = 1'b0;
        done       = 4'h0;
        done_na    = 4'h0;

        // Normal run, then restart from DONE at cycle 100.
        do_reset();
        for (int c = 0; c <= 120; c++) begin
            done    = 4'hF;
            restart = (c == 100);
            if (c <= 100) push(1'b0, exp_ack(c, 1'b0), "normal");
            else          push(1'b0, exp_ack(c - 101, 1'b1), "restart");
            push(1'b1, exp_nack(c), "noack");
            tick();
        end

        // Timeout on channel 2, then restart held for cycles 76..78.
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            done    = 4'b1011;
            restart = (c >= 76) && (c <= 78);
            if (c <= 76) push(1'b0, exp_tout(c), "timeout");
            else         push(1'b0, exp_ack(c - 79, 1'b1), "rst_held");
            push(1'b1, exp_nack(c), "noack_b");
            tick();
        end

        // Ack and timeout on the same edge.
        do_reset();
        for (int c = 0; c <= 105; c++) begin
            done    = (c == 68) ? 4'b1111 : 4'b1011;
            restart = 1'b0;
            push(1'b0, exp_coll(c), "collide");
            push(1'b1, exp_nack(c), "noack_c");
            tick();
        end

        // Asynchronous reset between edges while waiting for channel 2.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            done = 4'b1011;
            push(1'b0, exp_tout(c), "pre_arst");
            tick();
        end
        check_vec("wait_ack_c60", 32'(obs), 32'(exp_tout(60)));
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("arst_dut", 32'(obs), 32'd0);
        check_vec("arst_noack", 32'(obs_na), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 0; c <= 40; c++) begin
            done = 4'hF;
            push(1'b0, exp_ack(c, 1'b0), "post_arst");
            push(1'b1, exp_nack(c), "noack_d");
            tick();
        end

        @(negedge clk);
        check_vec("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
